// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor calls, moves one floor per
// MOVE_TICKS slow ticks, holds the door for DOOR_TICKS ticks.
module elevator_ctrl #(
  parameter int NUM_FLOORS = 4,
  parameter int MOVE_TICKS = 3,
  parameter int DOOR_TICKS = 6,
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1,
  localparam int CW = $clog2(((MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_slow,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FW-1:0]         floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [FW-1:0]           floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    last_dir_q, last_dir_d;
  logic [CW-1:0]           move_cnt_q, move_cnt_d;
  logic [CW-1:0]           door_cnt_q, door_cnt_d;

  logic                    sync1_q, sync2_q, prev_q, tick_q;
  logic [1:0]              warm_q;

  logic [NUM_FLOORS-1:0]   pend_eff, clr;
  logic [FW-1:0]           floor_up, floor_dn;

  function automatic logic has_above(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic has_below(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  // Edge history is held at 1 until the synchronizer has refilled after reset,
  // so a clk_slow that is already high at release does not produce a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b1;
      warm_q  <= 2'b00;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= clk_slow;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
      prev_q  <= warm_q[1] ? sync2_q : 1'b1;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      floor_q    <= '0;
      pending_q  <= '0;
      last_dir_q <= 1'b1;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      pending_q  <= pending_d;
      last_dir_q <= last_dir_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  always_comb begin
    pend_eff   = pending_q | req;
    clr        = '0;
    floor_up   = floor_q + FW'(1);
    floor_dn   = floor_q - FW'(1);
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_eff[floor_q]) begin
          clr[floor_q] = 1'b1;
          state_d      = S_DOOR_OPEN;
          door_cnt_d   = '0;
        end else if (has_above(pend_eff, floor_q) &&
                     (last_dir_q || !has_below(pend_eff, floor_q))) begin
          state_d    = S_MOVE_UP;
          last_dir_d = 1'b1;
          move_cnt_d = '0;
        end else if (has_below(pend_eff, floor_q)) begin
          state_d    = S_MOVE_DOWN;
          last_dir_d = 1'b0;
          move_cnt_d = '0;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tick_q) begin
          if (move_cnt_q == CW'(MOVE_TICKS - 1)) begin
            move_cnt_d = '0;
            floor_d    = (state_q == S_MOVE_UP) ? floor_up : floor_dn;
            if (pend_eff[floor_d]) begin
              clr[floor_d] = 1'b1;
              state_d      = S_DOOR_OPEN;
              door_cnt_d   = '0;
            end else if (state_q == S_MOVE_UP ? !has_above(pend_eff, floor_d)
                                              : !has_below(pend_eff, floor_d)) begin
              state_d = S_IDLE;
            end
          end else begin
            move_cnt_d = move_cnt_q + CW'(1);
          end
        end
      end
      S_DOOR_OPEN: begin
        // A call for this floor while the door is open is absorbed and holds it open.
        clr[floor_q] = 1'b1;
        if (pend_eff[floor_q]) begin
          door_cnt_d = '0;
        end else if (tick_q) begin
          if (door_cnt_q == CW'(DOOR_TICKS - 1)) begin
            state_d    = S_IDLE;
            door_cnt_d = '0;
          end else begin
            door_cnt_d = door_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = pend_eff & ~clr;
  end

  always_comb begin
    floor       = floor_q;
    pending     = pending_q;
    state       = state_q;
    moving_up   = (state_q == S_MOVE_UP);
    moving_down = (state_q == S_MOVE_DOWN);
    door_open   = (state_q == S_DOOR_OPEN);
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios with literal expectations, then
// random calls/ticks/resets checked every cycle against a behavioural model.
module tb_elevator_ctrl;
  localparam int NF = 4;
  localparam int MT = 3;
  localparam int DT = 6;

  logic          clk, rst, clk_slow;
  logic [NF-1:0] req;
  logic [1:0]    floor;
  logic [NF-1:0] pending;
  logic          moving_up, moving_down, door_open;
  logic [1:0]    state;

  elevator_ctrl #(.NUM_FLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .clk_slow(clk_slow), .req(req),
    .floor(floor), .pending(pending), .moving_up(moving_up),
    .moving_down(moving_down), .door_open(door_open), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit tick_at[int];

  // Model: 0 idle, 1 going up, 2 going down, 3 door open.
  int            m_state = 0;
  int            m_floor = 0;
  int            m_prog  = 0;
  int            m_door  = 0;
  bit            m_up    = 1'b1;
  logic [NF-1:0] m_pend  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit calls_above(input logic [NF-1:0] p, input int f);
    for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_below(input logic [NF-1:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [NF-1:0] calls;
    bit            tick;
    if (rst) begin
      m_state = 0; m_floor = 0; m_prog = 0; m_door = 0; m_up = 1'b1; m_pend = '0;
      tick_at.delete();
    end else begin
      calls = m_pend | req;
      tick  = tick_at.exists(cyc);
      if (tick) tick_at.delete(cyc);
      case (m_state)
        0: begin
          if (calls[m_floor]) begin
            calls[m_floor] = 1'b0; m_state = 3; m_door = 0;
          end else begin
            bit ab, be;
            ab = calls_above(calls, m_floor);
            be = calls_below(calls, m_floor);
            if ((m_up && ab) || (!m_up && ab && !be)) begin
              m_state = 1; m_up = 1'b1; m_prog = 0;
            end else if (be) begin
              m_state = 2; m_up = 1'b0; m_prog = 0;
            end
          end
        end
        1, 2: if (tick) begin
          m_prog++;
          if (m_prog == MT) begin
            m_prog  = 0;
            m_floor = m_floor + ((m_state == 1) ? 1 : -1);
            if (calls[m_floor]) begin
              calls[m_floor] = 1'b0; m_state = 3; m_door = 0;
            end else if (!((m_state == 1) ? calls_above(calls, m_floor)
                                          : calls_below(calls, m_floor))) begin
              m_state = 0;
            end
          end
        end
        default: begin
          if (calls[m_floor]) begin
            calls[m_floor] = 1'b0; m_door = 0;
          end else if (tick) begin
            m_door++;
            if (m_door == DT) begin m_state = 0; m_door = 0; end
          end
        end
      endcase
      m_pend = calls;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (int'(state) == m_state && int'(floor) == m_floor && pending == m_pend &&
        moving_up == (m_state == 1) && moving_down == (m_state == 2) &&
        door_open == (m_state == 3)) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_compare t=%0t: dut state=%0d floor=%0d pend=%b up=%b dn=%b door=%b; model state=%0d floor=%0d pend=%b",
               $time, state, floor, pending, moving_up, moving_down, door_open,
               m_state, m_floor, m_pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_pulse(input int hi, input int lo);
    clk_slow = 1'b1;
    tick_at[cyc + 3] = 1'b1;
    repeat (hi) step();
    clk_slow = 1'b0;
    repeat (lo) step();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_pulse(1, 2);
    repeat (2) step();
  endtask

  task automatic call(input logic [NF-1:0] v);
    req = v;
    step();
    req = '0;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    req = '0; clk_slow = 1'b0; rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    rst = 1'b1; clk_slow = 1'b0; req = '0;
    repeat (3) step();
    #4;
    check_lit("reset_state", int'(state), 0);
    check_lit("reset_floor", int'(floor), 0);
    check_lit("reset_outs", int'({pending, moving_up, moving_down, door_open}), 0);
    rst = 1'b0;
    repeat (5) step();

    // Call at current floor opens the door at once for 6 ticks.
    call(4'b0001); #4;
    check_lit("door_now_state", int'(state), 3);
    check_lit("door_now_pend", int'(pending), 0);
    ticks(5); #4;
    check_lit("door_after5", int'(door_open), 1);
    ticks(1); #4;
    check_lit("door_after6", int'(state), 0);

    // Travel 0 -> 3.
    call(4'b1000); #4;
    check_lit("up_state", int'(state), 1);
    check_lit("up_pend", int'(pending), 8);
    ticks(2); #4;
    check_lit("up_t2_floor", int'(floor), 0);
    ticks(1); #4;
    check_lit("up_t3_floor", int'(floor), 1);
    ticks(3); #4;
    check_lit("up_t6_floor", int'(floor), 2);
    ticks(3); #4;
    check_lit("up_t9_floor", int'(floor), 3);
    check_lit("up_t9_state", int'(state), 3);
    check_lit("up_t9_pend", int'(pending), 0);
    ticks(6);

    // Return to 0, then a downward call while travelling up.
    call(4'b0001);
    ticks(9); ticks(6);
    call(4'b1000);
    ticks(3); #4;
    check_lit("rev_floor1", int'(floor), 1);
    call(4'b0001); #4;
    check_lit("rev_pend", int'(pending), 9);
    ticks(6); #4;
    check_lit("rev_top_floor", int'(floor), 3);
    check_lit("rev_top_state", int'(state), 3);
    ticks(6); #4;
    check_lit("rev_down_state", int'(state), 2);
    ticks(9); #4;
    check_lit("rev_bottom_floor", int'(floor), 0);
    check_lit("rev_bottom_state", int'(state), 3);
    ticks(6);

    // Re-call of the open floor restarts the door timer.
    call(4'b0100);
    ticks(6);
    ticks(4);
    call(4'b0100); #4;
    check_lit("hold_pend", int'(pending), 0);
    ticks(5); #4;
    check_lit("hold_still_open", int'(state), 3);
    ticks(1); #4;
    check_lit("hold_closed", int'(state), 0);

    // Reset in mid-flight drops everything.
    call(4'b0001);
    ticks(6); ticks(6);
    call(4'b1100);
    ticks(4); #4;
    check_lit("pre_rst_pend", int'(pending), 12);
    check_lit("pre_rst_floor", int'(floor), 1);
    rst = 1'b1; #1;
    check_lit("rst_state", int'(state), 0);
    check_lit("rst_floor", int'(floor), 0);
    check_lit("rst_pend", int'(pending), 0);
    step();
    rst = 1'b0;
    repeat (5) step();
    ticks(3); #4;
    check_lit("post_rst_idle", int'(state), 0);
    check_lit("post_rst_floor", int'(floor), 0);

    // A long high level on clk_slow counts as one tick.
    call(4'b0010);
    ticks(1);
    tick_pulse(100, 3);
    repeat (2) step(); #4;
    check_lit("long_hi_floor", int'(floor), 0);
    check_lit("long_hi_state", int'(state), 1);
    ticks(1); #4;
    check_lit("long_hi_arrive", int'(floor), 1);
    ticks(6);

    // clk_slow already high at reset release gives no tick.
    rst = 1'b1; clk_slow = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    call(4'b0100);
    repeat (10) step();
    clk_slow = 1'b0;
    repeat (3) step();
    ticks(2); #4;
    check_lit("fresh_edge_floor", int'(floor), 0);
    ticks(1); #4;
    check_lit("fresh_edge_arrive", int'(floor), 1);
    ticks(3); ticks(6);

    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 6) call(NF'($urandom_range(1, 15)));
      else if (r < 17) tick_pulse($urandom_range(1, 4), $urandom_range(1, 3));
      else if (r < 19) step();
      else do_reset();
    end
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 4, meaning the number of served floors, numbered 0..NUM_FLOORS-1.
REQ-002 The block SHALL have parameter MOVE_TICKS, default 3, meaning the number of ticks needed to travel one floor.
REQ-003 The block SHALL have parameter DOOR_TICKS, default 6, meaning the number of ticks the door stays open.
REQ-004 The block SHALL have input clk, 1 bit: system clock, 50 MHz.
REQ-005 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have input clk_slow, 1 bit: divided clock from the upstream clock divider, asynchronous to clk.
REQ-007 The block SHALL have input req, NUM_FLOORS bits: floor call buttons, one bit per floor, any pulse width of at least 1 clk.
REQ-008 The block SHALL have output floor, clog2(NUM_FLOORS) bits: current floor.
REQ-009 The block SHALL have output pending, NUM_FLOORS bits: latched, unserved calls.
REQ-010 The block SHALL have outputs moving_up and moving_down, 1 bit each: asserted in MOVE_UP and MOVE_DOWN respectively.
REQ-011 The block SHALL have output door_open, 1 bit: asserted in DOOR_OPEN.
REQ-012 The block SHALL have output state, 2 bits, with encoding IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3.

Function
REQ-013 Tick generation SHALL pass clk_slow through a 2-flop synchronizer in clk; tick is a 1-clk pulse on each synchronized rising edge.
REQ-014 Tick latency SHALL be 3 clk from a clk_slow rising edge to the tick pulse, and ticks SHALL be one-to-one with clk_slow rising edges.
REQ-015 All state, counter and pending updates SHALL occur on clk; timing advances only on tick cycles.
REQ-016 pending SHALL be updated every clk as pending <= (pending | req) & ~clr, where clr is the one-hot bit of the floor being served this cycle.
REQ-017 If req and clr hit the same bit in the same cycle, clear SHALL win.
REQ-018 "above" SHALL mean any pending bit with index > floor; "below" SHALL mean any pending bit with index < floor.
REQ-019 IDLE priority SHALL be: pending[floor] first -> DOOR_OPEN and clear that bit; otherwise requests in the last_dir direction -> MOVE in that direction; otherwise requests in the opposite direction -> MOVE opposite; otherwise stay in IDLE.
REQ-020 last_dir SHALL be 1 bit (1=up) and SHALL be updated on every entry to MOVE_UP or MOVE_DOWN.
REQ-021 In MOVE_UP/MOVE_DOWN, move_cnt SHALL increment on each tick; on the tick where move_cnt==MOVE_TICKS-1, floor SHALL step by +1/-1 and move_cnt SHALL reset to 0.
REQ-022 On arrival at a new floor: if pending[new floor] -> DOOR_OPEN and clear that bit; else if requests remain in the same direction -> stay in the move state; else -> IDLE.
REQ-023 floor SHALL never wrap or leave 0..NUM_FLOORS-1; a move state is only entered when a target exists in that direction.
REQ-024 In DOOR_OPEN, door_cnt SHALL increment on each tick; on the tick where door_cnt==DOOR_TICKS-1 -> IDLE.
REQ-025 In DOOR_OPEN, a new req for the current floor SHALL be absorbed (bit stays 0) and SHALL restart door_cnt to 0.
REQ-026 move_cnt and door_cnt SHALL be loaded with 0 on every state entry.
REQ-027 Outputs SHALL be registered or decoded purely from registered state, with no combinational path from req.

Reset
REQ-028 On rst, the block SHALL set state=IDLE, floor=0, pending=0, last_dir=up, counters=0, synchronizer flops=0, and drive all outputs low.
REQ-029 rst asserted mid-move or mid-door SHALL abort immediately; all calls SHALL be lost and the car SHALL report floor 0.
REQ-030 After rst release, the first tick SHALL require a fresh clk_slow rising edge.

Verification (NUM_FLOORS=4, MOVE_TICKS=3, DOOR_TICKS=6)
REQ-031 Call at floor 0 while idle at floor 0: req=0001 -> DOOR_OPEN next clk, pending stays 0000, door_open high for exactly 6 ticks, then IDLE.
REQ-032 req=1000 at floor 0: the bench SHALL check MOVE_UP, floor reaching 1, 2, 3 at ticks 3, 6, 9, then DOOR_OPEN with pending=0000.
REQ-033 At floor 1, moving up toward 3, pulse req=0001: the bench SHALL check that the car serves floor 3 first, then IDLE -> MOVE_DOWN, and the door opens at floor 0.
REQ-034 Pulse req=0100 during DOOR_OPEN at floor 2 on tick 4: the bench SHALL check that door_cnt restarts, the door closes 6 ticks later, and pending[2] stays 0.
REQ-035 Assert rst during MOVE_UP between floors 1 and 2 with pending=1100: the bench SHALL check state=IDLE, floor=0, pending=0000 immediately, and no motion afterwards without a new req.
REQ-036 Hold clk_slow high for 100 clk, then low: the bench SHALL check that exactly one tick is generated.
